// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- single-cycle-latency integer ALU for the little-computer datapath.
//
// Takes an opcode and two register operands. The result and the status flags
// are computed combinationally and registered on the rising clock edge, so
// they appear one clock after the operands are presented and are held until
// the next edge. A new operation may be issued every cycle; there is no
// handshake.
//
// Ports
//   clk     in   1           system clock, rising-edge active
//   rst     in   1           synchronous reset, active-high (wins over op)
//   op      in   AluOpWidth  operation select (see OP_* encodings)
//   reg1    in   RegWidth    operand A
//   reg2    in   RegWidth    operand B / shift amount (full unsigned value)
//   regOut  out  RegWidth    registered result
//   zero    out  1           registered: regOut == 0
//   neg     out  1           registered: regOut[RegWidth-1]
//   carry   out  1           registered: carry-out (ADD) / no-borrow (SUB)
//   ovf     out  1           registered: signed overflow (ADD/SUB)
// ---------------------------------------------------------------------------
module alu #(
  parameter int RegWidth   = 16,
  parameter int AluOpWidth = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpWidth-1:0] op,
  input  logic [RegWidth-1:0]   reg1,
  input  logic [RegWidth-1:0]   reg2,
  output logic [RegWidth-1:0]   regOut,
  output logic                  zero,
  output logic                  neg,
  output logic                  carry,
  output logic                  ovf
);

  localparam logic [AluOpWidth-1:0] OP_ADD   = AluOpWidth'(0);
  localparam logic [AluOpWidth-1:0] OP_SUB   = AluOpWidth'(1);
  localparam logic [AluOpWidth-1:0] OP_AND   = AluOpWidth'(2);
  localparam logic [AluOpWidth-1:0] OP_OR    = AluOpWidth'(3);
  localparam logic [AluOpWidth-1:0] OP_XOR   = AluOpWidth'(4);
  localparam logic [AluOpWidth-1:0] OP_NOR   = AluOpWidth'(5);
  localparam logic [AluOpWidth-1:0] OP_SL    = AluOpWidth'(6);
  localparam logic [AluOpWidth-1:0] OP_SRL   = AluOpWidth'(7);
  localparam logic [AluOpWidth-1:0] OP_SRA   = AluOpWidth'(8);
  localparam logic [AluOpWidth-1:0] OP_SLT   = AluOpWidth'(9);
  localparam logic [AluOpWidth-1:0] OP_SLTU  = AluOpWidth'(10);
  localparam logic [AluOpWidth-1:0] OP_PASSB = AluOpWidth'(11);
  localparam logic [AluOpWidth-1:0] OP_NOTA  = AluOpWidth'(12);

  localparam int                    ShamtWidth = $clog2(RegWidth);
  localparam int                    Msb        = RegWidth - 1;
  // Shift amounts at or above this saturate (all bits shifted out).
  localparam logic [RegWidth-1:0]   ShiftLimit = RegWidth'(RegWidth);

  logic [RegWidth:0]     sum_ext;
  logic [RegWidth:0]     diff_ext;
  logic [ShamtWidth-1:0] shamt;
  logic                  shift_big;
  logic                  lt_signed;
  logic                  lt_unsigned;
  logic [RegWidth-1:0]   result_next;
  logic                  carry_next;
  logic                  ovf_next;

  always_comb begin
    // Widened by one bit so the carry / borrow lands in bit RegWidth.
    sum_ext     = {1'b0, reg1} + {1'b0, reg2};
    diff_ext    = {1'b0, reg1} - {1'b0, reg2};
    shamt       = reg2[ShamtWidth-1:0];
    shift_big   = (reg2 >= ShiftLimit);
    lt_signed   = ($signed(reg1) < $signed(reg2));
    lt_unsigned = (reg1 < reg2);

    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;

    case (op)
      OP_ADD: begin
        result_next = sum_ext[RegWidth-1:0];
        carry_next  = sum_ext[RegWidth];
        ovf_next    = (reg1[Msb] == reg2[Msb]) && (sum_ext[Msb] != reg1[Msb]);
      end
      OP_SUB: begin
        result_next = diff_ext[RegWidth-1:0];
        // Top bit of the widened difference is the borrow; carry is its inverse.
        carry_next  = ~diff_ext[RegWidth];
        ovf_next    = (reg1[Msb] != reg2[Msb]) && (diff_ext[Msb] != reg1[Msb]);
      end
      OP_AND:   result_next = reg1 & reg2;
      OP_OR:    result_next = reg1 | reg2;
      OP_XOR:   result_next = reg1 ^ reg2;
      OP_NOR:   result_next = ~(reg1 | reg2);
      OP_SL:    result_next = shift_big ? '0 : (reg1 << shamt);
      OP_SRL:   result_next = shift_big ? '0 : (reg1 >> shamt);
      OP_SRA:   result_next = shift_big ? {RegWidth{reg1[Msb]}}
                                        : RegWidth'($signed(reg1) >>> shamt);
      OP_SLT:   result_next = {{(RegWidth-1){1'b0}}, lt_signed};
      OP_SLTU:  result_next = {{(RegWidth-1){1'b0}}, lt_unsigned};
      OP_PASSB: result_next = reg2;
      OP_NOTA:  result_next = ~reg1;
      // Reserved encodings fall through to the zero result / cleared flags.
      default: begin
        result_next = '0;
        carry_next  = 1'b0;
        ovf_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regOut <= '0;
      zero   <= 1'b1;
      neg    <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      regOut <= result_next;
      zero   <= (result_next == '0);
      neg    <= result_next[Msb];
      carry  <= carry_next;
      ovf    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- directed testbench for alu with hand-computed expected values.
// Each task drives its own vectors and compares {regOut, zero, neg, carry, ovf}
// one clock after the operands are presented.
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [3:0]  op;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic [15:0] regOut;
  logic        zero;
  logic        neg;
  logic        carry;
  logic        ovf;

  int n_checks;
  int n_fails;

  // Observed word: result, then zero/neg/carry/ovf.
  logic [19:0] obs;
  assign obs = {regOut, zero, neg, carry, ovf};

  alu #(.RegWidth(16), .AluOpWidth(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .op     (op),
    .reg1   (reg1),
    .reg2   (reg2),
    .regOut (regOut),
    .zero   (zero),
    .neg    (neg),
    .carry  (carry),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands, let one rising edge register them, sample 1 time unit later.
  task automatic apply(input logic r, input logic [3:0] o,
                       input logic [15:0] a, input logic [15:0] b);
    rst  = r;
    op   = o;
    reg1 = a;
    reg2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(1'b1, 4'd0, 16'h1234, 16'h4321);
    apply(1'b1, 4'd0, 16'h1234, 16'h4321);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++;
      $display("FAIL reset_state: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    apply(1'b0, 4'd0, 16'h0002, 16'h0000);
    n_checks++;
    if (obs !== {16'h0002, 4'b0000}) begin
      n_fails++; $display("FAIL add_2_0: got %h required %h", obs, {16'h0002, 4'b0000});
    end
    apply(1'b0, 4'd0, 16'h0002, 16'h0003);
    n_checks++;
    if (obs !== {16'h0005, 4'b0000}) begin
      n_fails++; $display("FAIL add_2_3: got %h required %h", obs, {16'h0005, 4'b0000});
    end
    apply(1'b0, 4'd0, 16'hFFFF, 16'h0001);
    n_checks++;
    if (obs !== {16'h0000, 4'b1010}) begin
      n_fails++; $display("FAIL add_carry: got %h required %h", obs, {16'h0000, 4'b1010});
    end
    apply(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    n_checks++;
    if (obs !== {16'h8000, 4'b0101}) begin
      n_fails++; $display("FAIL add_ovf: got %h required %h", obs, {16'h8000, 4'b0101});
    end
  endtask

  task automatic test_shift;
    apply(1'b0, 4'd6, 16'h0002, 16'h0003);
    n_checks++;
    if (obs !== {16'h0010, 4'b0000}) begin
      n_fails++; $display("FAIL sl_2_3: got %h required %h", obs, {16'h0010, 4'b0000});
    end
    apply(1'b0, 4'd6, 16'h0002, 16'h0000);
    n_checks++;
    if (obs !== {16'h0002, 4'b0000}) begin
      n_fails++; $display("FAIL sl_by_0: got %h required %h", obs, {16'h0002, 4'b0000});
    end
    apply(1'b0, 4'd6, 16'h0001, 16'h0010);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL sl_by_16: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd6, 16'h0001, 16'h000F);
    n_checks++;
    if (obs !== {16'h8000, 4'b0100}) begin
      n_fails++; $display("FAIL sl_by_15: got %h required %h", obs, {16'h8000, 4'b0100});
    end
    apply(1'b0, 4'd8, 16'h8000, 16'h000F);
    n_checks++;
    if (obs !== {16'hFFFF, 4'b0100}) begin
      n_fails++; $display("FAIL sra_15: got %h required %h", obs, {16'hFFFF, 4'b0100});
    end
    apply(1'b0, 4'd7, 16'h8000, 16'h000F);
    n_checks++;
    if (obs !== {16'h0001, 4'b0000}) begin
      n_fails++; $display("FAIL srl_15: got %h required %h", obs, {16'h0001, 4'b0000});
    end
    apply(1'b0, 4'd8, 16'h8000, 16'h0010);
    n_checks++;
    if (obs !== {16'hFFFF, 4'b0100}) begin
      n_fails++; $display("FAIL sra_16: got %h required %h", obs, {16'hFFFF, 4'b0100});
    end
    apply(1'b0, 4'd8, 16'h4000, 16'h0014);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL sra_20_pos: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd7, 16'h8000, 16'h0100);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL srl_256: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd8, 16'h8001, 16'h0000);
    n_checks++;
    if (obs !== {16'h8001, 4'b0100}) begin
      n_fails++; $display("FAIL sra_by_0: got %h required %h", obs, {16'h8001, 4'b0100});
    end
  endtask

  task automatic test_sub;
    apply(1'b0, 4'd1, 16'h8000, 16'h0001);
    n_checks++;
    if (obs !== {16'h7FFF, 4'b0011}) begin
      n_fails++; $display("FAIL sub_ovf: got %h required %h", obs, {16'h7FFF, 4'b0011});
    end
    apply(1'b0, 4'd1, 16'h0001, 16'h0002);
    n_checks++;
    if (obs !== {16'hFFFF, 4'b0100}) begin
      n_fails++; $display("FAIL sub_borrow: got %h required %h", obs, {16'hFFFF, 4'b0100});
    end
    apply(1'b0, 4'd1, 16'h0005, 16'h0005);
    n_checks++;
    if (obs !== {16'h0000, 4'b1010}) begin
      n_fails++; $display("FAIL sub_equal: got %h required %h", obs, {16'h0000, 4'b1010});
    end
  endtask

  task automatic test_compare_logic;
    apply(1'b0, 4'd9, 16'hFFFF, 16'h0001);
    n_checks++;
    if (obs !== {16'h0001, 4'b0000}) begin
      n_fails++; $display("FAIL slt: got %h required %h", obs, {16'h0001, 4'b0000});
    end
    apply(1'b0, 4'd10, 16'hFFFF, 16'h0001);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL sltu: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd10, 16'h0001, 16'hFFFF);
    n_checks++;
    if (obs !== {16'h0001, 4'b0000}) begin
      n_fails++; $display("FAIL sltu_true: got %h required %h", obs, {16'h0001, 4'b0000});
    end
    apply(1'b0, 4'd2, 16'h0F0F, 16'h00FF);
    n_checks++;
    if (obs !== {16'h000F, 4'b0000}) begin
      n_fails++; $display("FAIL and: got %h required %h", obs, {16'h000F, 4'b0000});
    end
    apply(1'b0, 4'd3, 16'h0F0F, 16'h00FF);
    n_checks++;
    if (obs !== {16'h0FFF, 4'b0000}) begin
      n_fails++; $display("FAIL or: got %h required %h", obs, {16'h0FFF, 4'b0000});
    end
    apply(1'b0, 4'd4, 16'h0F0F, 16'h00FF);
    n_checks++;
    if (obs !== {16'h0FF0, 4'b0000}) begin
      n_fails++; $display("FAIL xor: got %h required %h", obs, {16'h0FF0, 4'b0000});
    end
    apply(1'b0, 4'd5, 16'h0F0F, 16'h00FF);
    n_checks++;
    if (obs !== {16'hF000, 4'b0100}) begin
      n_fails++; $display("FAIL nor: got %h required %h", obs, {16'hF000, 4'b0100});
    end
  endtask

  task automatic test_unary_reserved;
    apply(1'b0, 4'd11, 16'hAAAA, 16'h1234);
    n_checks++;
    if (obs !== {16'h1234, 4'b0000}) begin
      n_fails++; $display("FAIL passb: got %h required %h", obs, {16'h1234, 4'b0000});
    end
    apply(1'b0, 4'd12, 16'h00FF, 16'h1234);
    n_checks++;
    if (obs !== {16'hFF00, 4'b0100}) begin
      n_fails++; $display("FAIL nota: got %h required %h", obs, {16'hFF00, 4'b0100});
    end
    apply(1'b0, 4'd13, 16'hFFFF, 16'hFFFF);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL reserved_13: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd15, 16'h8000, 16'h8000);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL reserved_15: got %h required %h", obs, {16'h0000, 4'b1000});
    end
  endtask

  task automatic test_reset_priority;
    apply(1'b1, 4'd0, 16'h0005, 16'h0005);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL rst_over_add: got %h required %h", obs, {16'h0000, 4'b1000});
    end
    apply(1'b0, 4'd0, 16'h0005, 16'h0005);
    n_checks++;
    if (obs !== {16'h000A, 4'b0000}) begin
      n_fails++; $display("FAIL resume_add: got %h required %h", obs, {16'h000A, 4'b0000});
    end
  endtask

  task automatic test_back_to_back;
    apply(1'b0, 4'd1, 16'h0001, 16'h0002);
    n_checks++;
    if (obs !== {16'hFFFF, 4'b0100}) begin
      n_fails++; $display("FAIL b2b_sub: got %h required %h", obs, {16'hFFFF, 4'b0100});
    end
    // New operands without an edge must not disturb the held result.
    op   = 4'd0;
    reg1 = 16'h0003;
    reg2 = 16'h0004;
    #3;
    n_checks++;
    if (obs !== {16'hFFFF, 4'b0100}) begin
      n_fails++; $display("FAIL b2b_hold: got %h required %h", obs, {16'hFFFF, 4'b0100});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== {16'h0007, 4'b0000}) begin
      n_fails++; $display("FAIL b2b_add: got %h required %h", obs, {16'h0007, 4'b0000});
    end
    apply(1'b0, 4'd12, 16'hFFFF, 16'h0000);
    n_checks++;
    if (obs !== {16'h0000, 4'b1000}) begin
      n_fails++; $display("FAIL b2b_nota: got %h required %h", obs, {16'h0000, 4'b1000});
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    op       = 4'd0;
    reg1     = 16'h0000;
    reg2     = 16'h0000;
    test_reset();
    test_add();
    test_shift();
    test_sub();
    test_compare_logic();
    test_unary_reserved();
    test_reset_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
